addsub_seq: RTL



---
 rtl/addsub_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// addsub_seq: chunk-serial signed adder/subtractor (CHUNK bits per clock) with valid/ready handshakes.
// Define SATURATE_EN to clamp overflowed results to the signed limits instead of wrapping.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SATURATE_EN
  logic             a_neg_q, a_neg_d;
`endif

  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] final_s;
  logic             msb_cin_s;
  logic             ovf_s;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Ripple stage on the low chunk of the shifting operands; accumulator fills from the top.
  always_comb begin
    chunk_sum_s = chunk_add(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry_q);
    raw_s       = WIDTH'({chunk_sum_s[CHUNK-1:0], acc_q} >> CHUNK);
    // Only meaningful on the MSB chunk: recover the carry into the sign bit from its sum bit.
    msb_cin_s   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
    ovf_s       = msb_cin_s ^ chunk_sum_s[CHUNK];
`ifdef SATURATE_EN
    if (ovf_s) begin
      final_s = a_neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_s = raw_s;
    end
`else
    final_s = raw_s;
`endif
  end

  // Next-state and next-register logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`ifdef SATURATE_EN
    a_neg_d  = a_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          sub_d   = sub;
          acc_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
`ifdef SATURATE_EN
          a_neg_d = a[WIDTH-1];
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = raw_s;
        carry_d = chunk_sum_s[CHUNK];
        if (cnt_q == LAST_CHUNK) begin
          cnt_d   = {CW{1'b0}};
          res_d   = final_s;
          cout_d  = sub_q ^ chunk_sum_s[CHUNK];
          ovf_d   = ovf_s;
          zero_d  = (final_s == {WIDTH{1'b0}});
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Register bank; asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      res_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SATURATE_EN
      a_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SATURATE_EN
      a_neg_q     <= a_neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
